// File: rtl/mem_ctrl_pkg.sv
// Shared types and widths for the LPDDR5 controller command path.
//   mem_ctrl_cmd_t : packed command {id, addr, is_write, len, size, burst},
//                    MSB-first, identical to the push_data_i layout.
package mem_ctrl_pkg;

  localparam int unsigned ID_W    = 8;
  localparam int unsigned ADDR_W  = 40;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  // is_write + len + size + burst
  localparam int unsigned CTRL_W  = 1 + LEN_W + SIZE_W + BURST_W;
  localparam int unsigned CMD_W   = ID_W + ADDR_W + CTRL_W;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [ADDR_W-1:0]  addr;
    logic               is_write;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } mem_ctrl_cmd_t;

endpackage : mem_ctrl_pkg

// File: rtl/mem_ctrl_cmd_fifo_mem.sv
// Command storage: DEPTH x WIDTH register array, one synchronous write
// port and one asynchronous read port.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
module mem_ctrl_cmd_fifo_mem
  import mem_ctrl_pkg::*;
#(
  parameter  int unsigned DEPTH = 64,
  parameter  int unsigned WIDTH = CMD_W,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  // Payload storage is not reset; contents are qualified by the occupancy count.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : mem_ctrl_cmd_fifo_mem

// File: rtl/mem_ctrl_cmd_queue.sv
// Command FIFO between the AXI4 slave and the DRAM command scheduler.
//   push_en_i/push_data_i        : one packed command per cycle in
//   full_o                       : early back-pressure (FULL_MARGIN slots left)
//   empty_o, count_o             : occupancy
//   pop_valid_o/pop_ready_i      : head handshake; pop_*_o are the decoded head fields
//   wr_pending_o/rd_pending_o    : queued writes / reads
//   flush_i                      : synchronous discard of all entries
//   overflow_o/overflow_clr_i    : sticky dropped-push flag and its clear
module mem_ctrl_cmd_queue
  import mem_ctrl_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH  = ADDR_W,
  parameter  int unsigned ID_WIDTH    = ID_W,
  parameter  int unsigned DEPTH       = 64,
  parameter  int unsigned FULL_MARGIN = 2,
  localparam int unsigned PTR_W       = $clog2(DEPTH),
  localparam int unsigned CNT_W       = $clog2(DEPTH) + 1,
  localparam int unsigned DATA_W      = ID_WIDTH + ADDR_WIDTH + CTRL_W
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  push_en_i,
  input  logic [DATA_W-1:0]     push_data_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  pop_valid_o,
  input  logic                  pop_ready_i,
  output logic [ID_WIDTH-1:0]   pop_id_o,
  output logic [ADDR_WIDTH-1:0] pop_addr_o,
  output logic                  pop_is_write_o,
  output logic [LEN_W-1:0]      pop_len_o,
  output logic [SIZE_W-1:0]     pop_size_o,
  output logic [BURST_W-1:0]    pop_burst_o,
  output logic [CNT_W-1:0]      count_o,
  output logic [CNT_W-1:0]      wr_pending_o,
  output logic [CNT_W-1:0]      rd_pending_o,
  input  logic                  flush_i,
  output logic                  overflow_o,
  input  logic                  overflow_clr_i
);

  // Bit position of is_write within a packed command
  localparam int unsigned WBIT = CTRL_W - 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  wr_pend_q, wr_pend_d;
  logic [CNT_W-1:0]  rd_pend_q, rd_pend_d;
  logic              overflow_q, overflow_d;

  logic              is_full_c;
  logic              push_acc_c;
  logic              pop_fire_c;
  logic              push_wr_c;
  logic              head_wr_c;
  logic [DATA_W-1:0] head_c;

  mem_ctrl_cmd_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push_acc_c),
    .waddr_i (wr_ptr_q),
    .wdata_i (push_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_c)
  );

  // Handshake qualification; flush overrides both sides
  always_comb begin
    is_full_c  = (count_q == CNT_W'(DEPTH));
    push_acc_c = push_en_i && !is_full_c && !flush_i;
    pop_fire_c = pop_valid_o && pop_ready_i && !flush_i;
    push_wr_c  = push_data_i[WBIT];
    head_wr_c  = head_c[WBIT];
  end

  // Next-state for pointers, counters and the sticky overflow flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wr_pend_d  = wr_pend_q;
    rd_pend_d  = rd_pend_q;
    overflow_d = overflow_q;

    if (flush_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      wr_pend_d = '0;
      rd_pend_d = '0;
    end else begin
      if (push_acc_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_fire_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d   = count_q + CNT_W'(push_acc_c) - CNT_W'(pop_fire_c);
      wr_pend_d = wr_pend_q + CNT_W'(push_acc_c && push_wr_c)
                            - CNT_W'(pop_fire_c && head_wr_c);
      rd_pend_d = rd_pend_q + CNT_W'(push_acc_c && !push_wr_c)
                            - CNT_W'(pop_fire_c && !head_wr_c);
    end

    // Clear first so a same-cycle drop still leaves the flag set
    if (overflow_clr_i) overflow_d = 1'b0;
    if (push_en_i && is_full_c && !flush_i) overflow_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_pend_q  <= '0;
      rd_pend_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_pend_q  <= wr_pend_d;
      rd_pend_q  <= rd_pend_d;
      overflow_q <= overflow_d;
    end
  end

  // Status and decoded head, combinational from registered state / storage
  assign count_o        = count_q;
  assign wr_pending_o   = wr_pend_q;
  assign rd_pending_o   = rd_pend_q;
  assign overflow_o     = overflow_q;
  assign empty_o        = (count_q == '0);
  assign pop_valid_o    = (count_q != '0);
  assign full_o         = (count_q >= CNT_W'(DEPTH - FULL_MARGIN));

  assign pop_id_o       = head_c[DATA_W-1 -: ID_WIDTH];
  assign pop_addr_o     = head_c[CTRL_W +: ADDR_WIDTH];
  assign pop_is_write_o = head_c[WBIT];
  assign pop_len_o      = head_c[SIZE_W+BURST_W +: LEN_W];
  assign pop_size_o     = head_c[BURST_W +: SIZE_W];
  assign pop_burst_o    = head_c[0 +: BURST_W];

endmodule : mem_ctrl_cmd_queue

// File: tb/tb_mem_ctrl_cmd_queue.sv
// Directed bench for mem_ctrl_cmd_queue with a command scoreboard and a
// reference occupancy / pending / overflow model.
module tb_mem_ctrl_cmd_queue;
  import mem_ctrl_pkg::*;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                push_en = 1'b0;
  mem_ctrl_cmd_t       push_data = '0;
  logic                full, empty, pop_valid;
  logic                pop_ready = 1'b0;
  logic [ID_W-1:0]     pop_id;
  logic [ADDR_W-1:0]   pop_addr;
  logic                pop_is_write;
  logic [LEN_W-1:0]    pop_len;
  logic [SIZE_W-1:0]   pop_size;
  logic [BURST_W-1:0]  pop_burst;
  logic [CNT_W-1:0]    count, wr_pend, rd_pend;
  logic                flush = 1'b0;
  logic                overflow;
  logic                ovf_clr = 1'b0;

  always #5 clk = ~clk;

  mem_ctrl_cmd_queue #(
    .ADDR_WIDTH (ADDR_W),
    .ID_WIDTH   (ID_W),
    .DEPTH      (DEPTH),
    .FULL_MARGIN(2)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .push_en_i      (push_en),
    .push_data_i    (push_data),
    .full_o         (full),
    .empty_o        (empty),
    .pop_valid_o    (pop_valid),
    .pop_ready_i    (pop_ready),
    .pop_id_o       (pop_id),
    .pop_addr_o     (pop_addr),
    .pop_is_write_o (pop_is_write),
    .pop_len_o      (pop_len),
    .pop_size_o     (pop_size),
    .pop_burst_o    (pop_burst),
    .count_o        (count),
    .wr_pending_o   (wr_pend),
    .rd_pending_o   (rd_pend),
    .flush_i        (flush),
    .overflow_o     (overflow),
    .overflow_clr_i (ovf_clr)
  );

  int            n_cmp = 0;
  int            n_err = 0;
  mem_ctrl_cmd_t sb[$];
  int            m_cnt = 0;
  int            m_wr  = 0;
  int            m_rd  = 0;
  bit            m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic mem_ctrl_cmd_t rnd_cmd(input bit w);
    mem_ctrl_cmd_t c;
    c.id       = ID_W'($urandom);
    c.addr     = {8'($urandom), 32'($urandom)};
    c.is_write = w;
    c.len      = LEN_W'($urandom);
    c.size     = SIZE_W'($urandom);
    c.burst    = BURST_W'($urandom);
    return c;
  endfunction

  task automatic drive(input bit pe, input mem_ctrl_cmd_t d, input bit pr,
                       input bit fl, input bit clr);
    push_en   = pe;
    push_data = d;
    pop_ready = pr;
    flush     = fl;
    ovf_clr   = clr;
  endtask

  task automatic check_status();
    chk("count",     64'(count),     64'(m_cnt));
    chk("wr_pend",   64'(wr_pend),   64'(m_wr));
    chk("rd_pend",   64'(rd_pend),   64'(m_rd));
    chk("pop_valid", 64'(pop_valid), 64'(m_cnt != 0));
    chk("empty",     64'(empty),     64'(m_cnt == 0));
    chk("full",      64'(full),      64'(m_cnt >= int'(DEPTH) - 2));
    chk("overflow",  64'(overflow),  64'(m_ovf));
  endtask

  // One clock: check head if it will be taken, update the model, then check status
  task automatic tick();
    mem_ctrl_cmd_t h;
    bit acc, fire;
    #1;
    fire = pop_ready && (m_cnt != 0) && !flush;
    acc  = push_en && (m_cnt < int'(DEPTH)) && !flush;
    if (fire) begin
      h = sb[0];
      chk("head_valid", 64'(pop_valid),    64'd1);
      chk("head_id",    64'(pop_id),       64'(h.id));
      chk("head_addr",  64'(pop_addr),     64'(h.addr));
      chk("head_wr",    64'(pop_is_write), 64'(h.is_write));
      chk("head_len",   64'(pop_len),      64'(h.len));
      chk("head_size",  64'(pop_size),     64'(h.size));
      chk("head_burst", 64'(pop_burst),    64'(h.burst));
    end
    if (ovf_clr) m_ovf = 1'b0;
    if (push_en && !flush && m_cnt == int'(DEPTH)) m_ovf = 1'b1;
    if (flush) begin
      sb.delete();
      m_cnt = 0; m_wr = 0; m_rd = 0;
    end else begin
      if (fire) begin
        h = sb.pop_front();
        m_cnt--;
        if (h.is_write) m_wr--; else m_rd--;
      end
      if (acc) begin
        sb.push_back(push_data);
        m_cnt++;
        if (push_data.is_write) m_wr++; else m_rd++;
      end
    end
    @(posedge clk);
    #1;
    check_status();
  endtask

  initial begin
    mem_ctrl_cmd_t c;

    // Reset state
    #12;
    check_status();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single read, visible the cycle after push
    c = '{id: 8'h5A, addr: 40'h12_3456_7800, is_write: 1'b0, len: 4'd3, size: 3'd5, burst: 2'd1};
    drive(1, c, 0, 0, 0); tick();
    chk("t1_id",   64'(pop_id),       64'h5A);
    chk("t1_addr", 64'(pop_addr),     64'h12_3456_7800);
    chk("t1_wr",   64'(pop_is_write), 64'd0);
    chk("t1_len",  64'(pop_len),      64'd3);
    chk("t1_size", 64'(pop_size),     64'd5);
    chk("t1_bst",  64'(pop_burst),    64'd1);
    drive(0, '0, 1, 0, 0); tick();

    // 2: fill to full_o (62), then to 64, then a dropped push
    for (int i = 0; i < 62; i++) begin
      drive(1, rnd_cmd(i[0]), 0, 0, 0); tick();
    end
    chk("t2_full62", 64'(full), 64'd1);
    for (int i = 0; i < 2; i++) begin
      drive(1, rnd_cmd(1'b1), 0, 0, 0); tick();
    end
    chk("t2_cnt64", 64'(count), 64'd64);
    drive(1, rnd_cmd(1'b0), 0, 0, 0); tick();
    chk("t2_ovf", 64'(overflow), 64'd1);
    drive(0, '0, 0, 0, 1); tick();
    chk("t2_clr", 64'(overflow), 64'd0);

    // 4: full queue, push and pop together: pop fires, push dropped
    drive(1, rnd_cmd(1'b0), 1, 0, 0); tick();
    chk("t4_cnt63", 64'(count), 64'd63);
    chk("t4_ovf",   64'(overflow), 64'd1);

    // Overflow set and clear together: set wins (needs full again)
    drive(1, rnd_cmd(1'b1), 0, 0, 0); tick();
    drive(1, rnd_cmd(1'b0), 0, 0, 1); tick();
    chk("ovf_set_wins", 64'(overflow), 64'd1);
    drive(0, '0, 0, 0, 1); tick();

    // Drain
    while (m_cnt > 0) begin
      drive(0, '0, 1, 0, 0); tick();
    end

    // 3: steady push+pop for 200 cycles across pointer wrap
    drive(1, rnd_cmd(1'b1), 0, 0, 0); tick();
    for (int i = 0; i < 200; i++) begin
      drive(1, rnd_cmd(i[0]), 1, 0, 0); tick();
    end
    chk("t3_cnt1", 64'(count), 64'd1);
    drive(0, '0, 1, 0, 0); tick();

    // 5: flush with simultaneous push
    for (int i = 0; i < 10; i++) begin
      drive(1, rnd_cmd(i[1]), 0, 0, 0); tick();
    end
    chk("t5_cnt10", 64'(count), 64'd10);
    drive(1, rnd_cmd(1'b1), 1, 1, 0); tick();
    chk("t5_cnt0",  64'(count), 64'd0);
    chk("t5_empty", 64'(empty), 64'd1);
    drive(0, '0, 0, 0, 0); tick();

    // 6: async reset mid-traffic
    for (int i = 0; i < 20; i++) begin
      drive(1, rnd_cmd(i[0]), 0, 0, 0); tick();
    end
    chk("t6_cnt20", 64'(count), 64'd20);
    drive(1, rnd_cmd(1'b0), 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_cnt = 0; m_wr = 0; m_rd = 0; m_ovf = 1'b0;
    chk("t6_cnt_rst",  64'(count),     64'd0);
    chk("t6_valid",    64'(pop_valid), 64'd0);
    chk("t6_wr_rst",   64'(wr_pend),   64'd0);
    chk("t6_rd_rst",   64'(rd_pend),   64'd0);
    drive(0, '0, 0, 0, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_status();
    for (int i = 0; i < 5; i++) begin
      drive(1, rnd_cmd(i[0]), i > 1, 0, 0); tick();
    end
    while (m_cnt > 0) begin
      drive(0, '0, 1, 0, 0); tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mem_ctrl_cmd_queue
